// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable counter: direction encodings, wrap/saturate
// mode encodings and a helper that sizes the prescaler register.
package prog_counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Bits needed to hold 0..p-1, never less than one bit.
    function automatic int presc_bits(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/prog_counter_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// en=0 freezes the phase; reset or clr returns it to zero.
module prog_counter_prescaler
    import prog_counter_pkg::*;
#(
    parameter int PRESCALE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = presc_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    assign tick = en && (phase == LAST);

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with run-time modulus, load, prescaled enable,
// wrap or saturate at the terminal value, terminal-count pulse and compare flag.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH     = 19,
    parameter int               SATURATE  = 0,
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             cmp_hit
);

    localparam bit SAT_MODE = (SATURATE != MODE_WRAP);

    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] next_count;

    generate
        if (PRESCALE == 1) begin : g_no_prescale
            assign tick = en;
        end else begin : g_prescale
            prog_counter_prescaler #(
                .PRESCALE(PRESCALE)
            ) u_prescaler (
                .clk  (clk),
                .reset(reset),
                .clr  (load),
                .en   (en),
                .tick (tick)
            );
        end
    endgenerate

    // Up-count treats anything at or above mod_val as terminal so an
    // out-of-range load recovers on the next tick.
    always_comb begin
        terminal   = 1'b0;
        next_count = count;
        if (up_dn == CNT_DOWN) begin
            terminal   = (count == '0);
            if (terminal) begin
                next_count = SAT_MODE ? '0 : mod_val;
            end else begin
                next_count = count - 1'b1;
            end
        end else begin
            terminal   = (count >= mod_val);
            if (terminal) begin
                next_count = SAT_MODE ? mod_val : '0;
            end else begin
                next_count = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VAL;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
        end else if (tick) begin
            count <= next_count;
            tc    <= terminal;
        end else begin
            tc    <= 1'b0;
        end
    end

    assign cmp_hit = (count == cmp_val);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: four WIDTH=4 builds (wrap, saturate, prescale-3,
// prescale-3 with RESET_VAL=5) share one stimulus set; each task checks its feature.
module tb_prog_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] mod_val;
    logic [3:0] cmp_val;

    logic [3:0] cnt_w, cnt_s, cnt_p, cnt_r;
    logic       tc_w, tc_s, tc_p, tc_r;
    logic       hit_w, hit_s, hit_p, hit_r;

    int total = 0;
    int bad   = 0;

    prog_counter #(.WIDTH(4), .SATURATE(0), .PRESCALE(1), .RESET_VAL(4'd0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .cmp_val(cmp_val),
        .count(cnt_w), .tc(tc_w), .cmp_hit(hit_w)
    );

    prog_counter #(.WIDTH(4), .SATURATE(1), .PRESCALE(1), .RESET_VAL(4'd0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .cmp_val(cmp_val),
        .count(cnt_s), .tc(tc_s), .cmp_hit(hit_s)
    );

    prog_counter #(.WIDTH(4), .SATURATE(0), .PRESCALE(3), .RESET_VAL(4'd0)) dut_p (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .cmp_val(cmp_val),
        .count(cnt_p), .tc(tc_p), .cmp_hit(hit_p)
    );

    prog_counter #(.WIDTH(4), .SATURATE(0), .PRESCALE(3), .RESET_VAL(4'd5)) dut_r (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_val(mod_val), .cmp_val(cmp_val),
        .count(cnt_r), .tc(tc_r), .cmp_hit(hit_r)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1;
        load_val = 4'd0; mod_val = 4'd9; cmp_val = 4'd5;
        step();
        total++; if (cnt_w !== 4'd0) begin bad++; $display("FAIL reset_cnt_w got=%0d exp=0", cnt_w); end
        total++; if (cnt_s !== 4'd0) begin bad++; $display("FAIL reset_cnt_s got=%0d exp=0", cnt_s); end
        total++; if (cnt_p !== 4'd0) begin bad++; $display("FAIL reset_cnt_p got=%0d exp=0", cnt_p); end
        total++; if (cnt_r !== 4'd5) begin bad++; $display("FAIL reset_cnt_r got=%0d exp=5", cnt_r); end
        total++; if ({tc_w, tc_s, tc_p, tc_r} !== 4'b0000) begin bad++; $display("FAIL reset_tc got=%b exp=0000", {tc_w, tc_s, tc_p, tc_r}); end
        total++; if (hit_w !== 1'b0) begin bad++; $display("FAIL reset_hit_w got=%b exp=0", hit_w); end
        total++; if (hit_r !== 1'b1) begin bad++; $display("FAIL reset_hit_r got=%b exp=1", hit_r); end
        reset = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_w  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic       exp_tw [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [3:0] exp_s  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
        logic       exp_ts [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        mod_val = 4'd9; up_dn = 1'b1; en = 1'b1; load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            total++; if (cnt_w !== exp_w[i]) begin bad++; $display("FAIL up_cnt_w[%0d] got=%0d exp=%0d", i, cnt_w, exp_w[i]); end
            total++; if (tc_w !== exp_tw[i]) begin bad++; $display("FAIL up_tc_w[%0d] got=%b exp=%b", i, tc_w, exp_tw[i]); end
            total++; if (cnt_s !== exp_s[i]) begin bad++; $display("FAIL up_cnt_s[%0d] got=%0d exp=%0d", i, cnt_s, exp_s[i]); end
            total++; if (tc_s !== exp_ts[i]) begin bad++; $display("FAIL up_tc_s[%0d] got=%b exp=%b", i, tc_s, exp_ts[i]); end
        end
    endtask

    task automatic test_down();
        logic [3:0] exp_w  [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        logic       exp_tw [4] = '{0, 0, 1, 0};
        logic [3:0] exp_s  [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_ts [4] = '{0, 0, 1, 1};
        load = 1'b1; load_val = 4'd2; up_dn = 1'b0; en = 1'b1; mod_val = 4'd9;
        step();
        total++; if (cnt_w !== 4'd2 || tc_w !== 1'b0) begin bad++; $display("FAIL down_load_w got=%0d/%b exp=2/0", cnt_w, tc_w); end
        total++; if (cnt_s !== 4'd2 || tc_s !== 1'b0) begin bad++; $display("FAIL down_load_s got=%0d/%b exp=2/0", cnt_s, tc_s); end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (cnt_w !== exp_w[i] || tc_w !== exp_tw[i]) begin bad++; $display("FAIL down_w[%0d] got=%0d/%b exp=%0d/%b", i, cnt_w, tc_w, exp_w[i], exp_tw[i]); end
            total++; if (cnt_s !== exp_s[i] || tc_s !== exp_ts[i]) begin bad++; $display("FAIL down_s[%0d] got=%0d/%b exp=%0d/%b", i, cnt_s, tc_s, exp_s[i], exp_ts[i]); end
        end
    endtask

    task automatic test_prescale();
        logic       en_seq [7] = '{1, 1, 0, 1, 1, 1, 1};
        logic [3:0] exp_p  [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        logic [3:0] exp_r  [7] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7};
        reset = 1'b1; load = 1'b0; en = 1'b0;
        step();
        reset = 1'b0; up_dn = 1'b1; mod_val = 4'd9;
        for (int i = 0; i < 7; i++) begin
            en = en_seq[i];
            step();
            total++; if (cnt_p !== exp_p[i] || tc_p !== 1'b0) begin bad++; $display("FAIL presc_p[%0d] got=%0d/%b exp=%0d/0", i, cnt_p, tc_p, exp_p[i]); end
            total++; if (cnt_r !== exp_r[i]) begin bad++; $display("FAIL presc_r[%0d] got=%0d exp=%0d", i, cnt_r, exp_r[i]); end
        end
    endtask

    task automatic test_priority();
        reset = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1; up_dn = 1'b1; mod_val = 4'd9;
        step();
        total++; if (cnt_w !== 4'd0) begin bad++; $display("FAIL prio_rst_load_w got=%0d exp=0", cnt_w); end
        total++; if (cnt_r !== 4'd5) begin bad++; $display("FAIL prio_rst_load_r got=%0d exp=5", cnt_r); end
        reset = 1'b0; load_val = 4'd9;
        step();
        total++; if (cnt_w !== 4'd9) begin bad++; $display("FAIL prio_load9_w got=%0d exp=9", cnt_w); end
        load_val = 4'd4;
        step();
        total++; if (cnt_w !== 4'd4 || tc_w !== 1'b0) begin bad++; $display("FAIL prio_load_tick_w got=%0d/%b exp=4/0", cnt_w, tc_w); end
        total++; if (cnt_s !== 4'd4 || tc_s !== 1'b0) begin bad++; $display("FAIL prio_load_tick_s got=%0d/%b exp=4/0", cnt_s, tc_s); end
        load = 1'b0;
        step();
        total++; if (cnt_w !== 4'd5 || tc_w !== 1'b0) begin bad++; $display("FAIL prio_after_load_w got=%0d/%b exp=5/0", cnt_w, tc_w); end
    endtask

    task automatic test_load_above();
        en = 1'b0; load = 1'b1; load_val = 4'd12; up_dn = 1'b1; mod_val = 4'd9;
        step();
        total++; if (cnt_w !== 4'd12 || cnt_s !== 4'd12) begin bad++; $display("FAIL above_load got=%0d/%0d exp=12/12", cnt_w, cnt_s); end
        load = 1'b0; en = 1'b1;
        step();
        total++; if (cnt_w !== 4'd0 || tc_w !== 1'b1) begin bad++; $display("FAIL above_tick_w got=%0d/%b exp=0/1", cnt_w, tc_w); end
        total++; if (cnt_s !== 4'd9 || tc_s !== 1'b1) begin bad++; $display("FAIL above_tick_s got=%0d/%b exp=9/1", cnt_s, tc_s); end
        step();
        total++; if (cnt_w !== 4'd1 || tc_w !== 1'b0) begin bad++; $display("FAIL above_next_w got=%0d/%b exp=1/0", cnt_w, tc_w); end
        total++; if (cnt_s !== 4'd9 || tc_s !== 1'b1) begin bad++; $display("FAIL above_hold_s got=%0d/%b exp=9/1", cnt_s, tc_s); end
        en = 1'b0;
        step();
        total++; if (cnt_s !== 4'd9 || tc_s !== 1'b0) begin bad++; $display("FAIL above_en0_s got=%0d/%b exp=9/0", cnt_s, tc_s); end
    endtask

    task automatic test_mod_zero();
        en = 1'b0; load = 1'b1; load_val = 4'd0; mod_val = 4'd0; up_dn = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (cnt_w !== 4'd0 || tc_w !== 1'b1) begin bad++; $display("FAIL mod0_w[%0d] got=%0d/%b exp=0/1", i, cnt_w, tc_w); end
        end
    endtask

    task automatic test_full_range();
        logic [3:0] exp_w  [3] = '{4'd15, 4'd0, 4'd1};
        logic       exp_tw [3] = '{0, 1, 0};
        en = 1'b0; load = 1'b1; load_val = 4'd14; mod_val = 4'd15; up_dn = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (cnt_w !== exp_w[i] || tc_w !== exp_tw[i]) begin bad++; $display("FAIL full_w[%0d] got=%0d/%b exp=%0d/%b", i, cnt_w, tc_w, exp_w[i], exp_tw[i]); end
        end
    endtask

    task automatic test_cmp();
        en = 1'b0; load = 1'b1; load_val = 4'd6; cmp_val = 4'd7; mod_val = 4'd9; up_dn = 1'b1;
        step();
        total++; if (cnt_w !== 4'd6 || hit_w !== 1'b0) begin bad++; $display("FAIL cmp_6 got=%0d/%b exp=6/0", cnt_w, hit_w); end
        load = 1'b0; en = 1'b1;
        step();
        total++; if (cnt_w !== 4'd7 || hit_w !== 1'b1) begin bad++; $display("FAIL cmp_7 got=%0d/%b exp=7/1", cnt_w, hit_w); end
        step();
        total++; if (cnt_w !== 4'd8 || hit_w !== 1'b0) begin bad++; $display("FAIL cmp_8 got=%0d/%b exp=8/0", cnt_w, hit_w); end
        en = 1'b0; cmp_val = 4'd8;
        #1;
        total++; if (hit_w !== 1'b1) begin bad++; $display("FAIL cmp_change got=%b exp=1", hit_w); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_p [3] = '{4'd0, 4'd0, 4'd1};
        logic [3:0] exp_r [3] = '{4'd5, 4'd5, 4'd6};
        reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd5; up_dn = 1'b1; mod_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1;
        step();
        step();
        total++; if (cnt_p !== 4'd5) begin bad++; $display("FAIL mid_pre_p got=%0d exp=5", cnt_p); end
        reset = 1'b1;
        step();
        total++; if (cnt_p !== 4'd0 || tc_p !== 1'b0) begin bad++; $display("FAIL mid_rst_p got=%0d/%b exp=0/0", cnt_p, tc_p); end
        total++; if (cnt_r !== 4'd5) begin bad++; $display("FAIL mid_rst_r got=%0d exp=5", cnt_r); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (cnt_p !== exp_p[i]) begin bad++; $display("FAIL mid_restart_p[%0d] got=%0d exp=%0d", i, cnt_p, exp_p[i]); end
            total++; if (cnt_r !== exp_r[i]) begin bad++; $display("FAIL mid_restart_r[%0d] got=%0d exp=%0d", i, cnt_r, exp_r[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0;
        load_val = 4'd0; mod_val = 4'd9; cmp_val = 4'd0;
        test_reset();
        test_up_wrap();
        test_down();
        test_prescale();
        test_priority();
        test_load_above();
        test_mod_zero();
        test_full_range();
        test_cmp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
